// File: rtl/cim_array_ctrl_if.sv
// Command/response bus for the CIM array controller: one command in, one
// response pulse out per command.
interface cim_array_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_dst;
  logic [AW-1:0]    cmd_srca;
  logic [AW-1:0]    cmd_srcb;
  logic [WIDTH-1:0] cmd_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
  );
endinterface

// File: rtl/cim_array_ctrl.sv
// Sequencer for a compute-in-memory row array: WRITE/READ/CLEAR/ADD commands
// become registered wordline, strobe and bitline activity plus one response.
module cim_array_ctrl #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cim_array_ctrl_if.slave  bus,
  output logic [ROWS-1:0]  gwl,
  output logic [ROWS-1:0]  rwl,
  output logic [ROWS-1:0]  wwl,
  output logic             clr,
  output logic             read_en,
  output logic             write_en,
  output logic [WIDTH-1:0] bl,
  output logic [WIDTH-1:0] from_adder,
  input  logic [WIDTH-1:0] sa,
  input  logic [WIDTH-1:0] to_adder
);

  typedef enum logic [2:0] {IDLE, WR, RD, CLR, ADD_A, ADD_B, ADD_WB, DONE} state_e;
  typedef enum logic [1:0] {OP_WRITE, OP_READ, OP_CLEAR, OP_ADD} op_e;

  state_e           state;
  logic [AW-1:0]    dst_q, srca_q, srcb_q;
  logic             err_q;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] b_cap;
  logic [WIDTH:0]   sum_ab, sum_wb;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < ROWS;
  endfunction

  function automatic logic [ROWS-1:0] onehot(input logic [AW-1:0] a);
    return in_range(a) ? (ROWS'(1) << a) : '0;
  endfunction

  // from_adder is registered on entry to ADD_WB, so it needs operand B as it
  // is being captured; the response uses the registered operands.
  always_comb begin
    b_cap  = in_range(srcb_q) ? to_adder : '0;
    sum_ab = {1'b0, opa} + {1'b0, b_cap};
    sum_wb = {1'b0, opa} + {1'b0, opb};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_err   <= 1'b0;
      gwl           <= '0;
      rwl           <= '0;
      wwl           <= '0;
      clr           <= 1'b0;
      read_en       <= 1'b0;
      write_en      <= 1'b0;
      bl            <= '0;
      from_adder    <= '0;
      dst_q         <= '0;
      srca_q        <= '0;
      srcb_q        <= '0;
      err_q         <= 1'b0;
      opa           <= '0;
      opb           <= '0;
    end else begin
      gwl           <= '0;
      rwl           <= '0;
      wwl           <= '0;
      clr           <= 1'b0;
      read_en       <= 1'b0;
      write_en      <= 1'b0;
      bl            <= '0;
      from_adder    <= '0;
      bus.rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready <= 1'b0;
            dst_q         <= bus.cmd_dst;
            srca_q        <= bus.cmd_srca;
            srcb_q        <= bus.cmd_srcb;
            unique case (op_e'(bus.cmd_op))
              OP_WRITE: begin
                state    <= WR;
                gwl      <= onehot(bus.cmd_dst);
                write_en <= 1'b1;
                bl       <= bus.cmd_wdata;
                err_q    <= !in_range(bus.cmd_dst);
              end
              OP_READ: begin
                state   <= RD;
                gwl     <= onehot(bus.cmd_srca);
                read_en <= 1'b1;
                err_q   <= !in_range(bus.cmd_srca);
              end
              OP_CLEAR: begin
                state <= CLR;
                clr   <= 1'b1;
                err_q <= 1'b0;
              end
              OP_ADD: begin
                state <= ADD_A;
                rwl   <= onehot(bus.cmd_srca);
                err_q <= !(in_range(bus.cmd_srca) && in_range(bus.cmd_srcb)
                           && in_range(bus.cmd_dst));
              end
            endcase
          end
        end
        WR, CLR: begin
          state         <= DONE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= '0;
          bus.rsp_carry <= 1'b0;
          bus.rsp_err   <= err_q;
        end
        RD: begin
          state         <= DONE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= in_range(srca_q) ? sa : '0;
          bus.rsp_carry <= 1'b0;
          bus.rsp_err   <= err_q;
        end
        ADD_A: begin
          state <= ADD_B;
          opa   <= in_range(srca_q) ? to_adder : '0;
          rwl   <= onehot(srcb_q);
        end
        ADD_B: begin
          state      <= ADD_WB;
          opb        <= b_cap;
          wwl        <= onehot(dst_q);
          from_adder <= in_range(dst_q) ? sum_ab[WIDTH-1:0] : '0;
        end
        ADD_WB: begin
          state         <= DONE;
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= sum_wb[WIDTH-1:0];
          bus.rsp_carry <= sum_wb[WIDTH];
          bus.rsp_err   <= err_q;
        end
        DONE: begin
          state         <= IDLE;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cim_array_ctrl.sv
// Bench for cim_array_ctrl: a behavioural array, a per-cycle expectation
// schedule built from command semantics, and directed commands.
module tb_cim_array_ctrl;
  localparam int ROWS = 16;
  localparam int W    = 8;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic [ROWS-1:0] gwl, rwl, wwl;
  logic clr, read_en, write_en;
  logic [W-1:0] bl, from_adder, sa, to_adder;

  cim_array_ctrl_if #(.WIDTH(W), .AW(AW)) bus ();

  cim_array_ctrl #(.ROWS(ROWS), .WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gwl(gwl), .rwl(rwl), .wwl(wwl), .clr(clr),
    .read_en(read_en), .write_en(write_en), .bl(bl), .from_adder(from_adder),
    .sa(sa), .to_adder(to_adder)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Physical array driven by the DUT's strobes.
  bit [W-1:0] mem [ROWS];
  always @(posedge clk) begin
    for (int i = 0; i < ROWS; i++) begin
      if (clr) mem[i] <= '0;
      else if (write_en && gwl[i]) mem[i] <= bl;
      else if (wwl[i]) mem[i] <= from_adder;
    end
  end
  always_comb begin
    sa = '0;
    to_adder = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (gwl[i]) sa = sa | mem[i];
      if (rwl[i]) to_adder = to_adder | mem[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct packed {
    logic busy, rsp, clr, ren, wen, carry, err;
    logic [ROWS-1:0] gwl, rwl, wwl;
    logic [W-1:0] bl, fa, data;
    logic [1:0] eff;      // 1: write row, 2: clear all
    logic [7:0] row;
    logic [W-1:0] val;
  } exp_t;

  exp_t sched [int];
  int unsigned ref_mem [ROWS];
  logic [W-1:0] hold_data = '0;
  logic hold_carry = 1'b0, hold_err = 1'b0;

  function automatic logic [ROWS-1:0] row_bit(input int r);
    logic [ROWS-1:0] v = '0;
    if (r < ROWS) v[r] = 1'b1;
    return v;
  endfunction

  function automatic int unsigned rd_ref(input int r);
    return (r < ROWS) ? ref_mem[r] : 0;
  endfunction

  // Compare process plus model update, once per cycle.
  always @(negedge clk) begin
    exp_t e, s;
    int d, a, b;
    int unsigned va, vb, sum;
    if (cyc >= 1) begin
      e = sched.exists(cyc) ? sched[cyc] : '0;
      if (e.rsp) begin
        hold_data = e.data; hold_carry = e.carry; hold_err = e.err;
        if (e.eff == 2'd1) ref_mem[e.row] = e.val;
        if (e.eff == 2'd2) for (int i = 0; i < ROWS; i++) ref_mem[i] = 0;
      end
      if (bus.rsp_valid === 1'b1) pulses++;
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!e.busy));
      chk("gwl", 32'(gwl), 32'(e.gwl));
      chk("rwl", 32'(rwl), 32'(e.rwl));
      chk("wwl", 32'(wwl), 32'(e.wwl));
      chk("clr", 32'(clr), 32'(e.clr));
      chk("read_en", 32'(read_en), 32'(e.ren));
      chk("write_en", 32'(write_en), 32'(e.wen));
      chk("bl", 32'(bl), 32'(e.bl));
      chk("from_adder", 32'(from_adder), 32'(e.fa));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.rsp));
      chk("rsp_data", 32'(bus.rsp_data), 32'(hold_data));
      chk("rsp_carry", 32'(bus.rsp_carry), 32'(hold_carry));
      chk("rsp_err", 32'(bus.rsp_err), 32'(hold_err));
      sched.delete(cyc);

      if (!rst_n) begin
        sched.delete();
        hold_data = '0; hold_carry = 1'b0; hold_err = 1'b0;
      end else if (bus.cmd_valid && bus.cmd_ready) begin
        d = int'(bus.cmd_dst); a = int'(bus.cmd_srca); b = int'(bus.cmd_srcb);
        case (bus.cmd_op)
          2'd0: begin
            s = '0; s.busy = 1; s.gwl = row_bit(d); s.wen = 1; s.bl = bus.cmd_wdata;
            sched[cyc+1] = s;
            s = '0; s.busy = 1; s.rsp = 1; s.err = (d >= ROWS);
            s.eff = (d < ROWS) ? 2'd1 : 2'd0; s.row = 8'(d); s.val = bus.cmd_wdata;
            sched[cyc+2] = s;
          end
          2'd1: begin
            s = '0; s.busy = 1; s.gwl = row_bit(a); s.ren = 1;
            sched[cyc+1] = s;
            s = '0; s.busy = 1; s.rsp = 1; s.err = (a >= ROWS); s.data = W'(rd_ref(a));
            sched[cyc+2] = s;
          end
          2'd2: begin
            s = '0; s.busy = 1; s.clr = 1;
            sched[cyc+1] = s;
            s = '0; s.busy = 1; s.rsp = 1; s.eff = 2'd2;
            sched[cyc+2] = s;
          end
          default: begin
            va = rd_ref(a); vb = rd_ref(b); sum = va + vb;
            s = '0; s.busy = 1; s.rwl = row_bit(a); sched[cyc+1] = s;
            s = '0; s.busy = 1; s.rwl = row_bit(b); sched[cyc+2] = s;
            s = '0; s.busy = 1; s.wwl = row_bit(d);
            s.fa = (d < ROWS) ? W'(sum % 256) : '0;
            sched[cyc+3] = s;
            s = '0; s.busy = 1; s.rsp = 1; s.data = W'(sum % 256); s.carry = (sum > 255);
            s.err = (a >= ROWS) || (b >= ROWS) || (d >= ROWS);
            s.eff = (d < ROWS) ? 2'd1 : 2'd0; s.row = 8'(d); s.val = W'(sum % 256);
            sched[cyc+4] = s;
          end
        endcase
      end
    end
  end

  // Driver: entered and left at posedge+1.
  task automatic send(input logic [1:0] op, input int d, input int a, input int b,
                      input logic [W-1:0] wd, input bit keep, output int hs);
    bus.cmd_op = op; bus.cmd_dst = AW'(d); bus.cmd_srca = AW'(a);
    bus.cmd_srcb = AW'(b); bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 20 && hs < 0; i++) begin
      @(negedge clk);
      if (bus.cmd_ready && rst_n) hs = cyc;
      @(posedge clk); #1;
    end
    if (hs < 0) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: got none, expected handshake within 20 cycles");
    end
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, input int hs, input int lat,
                          input int dexp, input int cexp, input int eexp);
    int rc = -1;
    logic [W-1:0] dv = '0;
    logic cv = 1'b0, ev = 1'b0;
    for (int i = 0; i < 10 && rc < 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rc = cyc; dv = bus.rsp_data; cv = bus.rsp_carry; ev = bus.rsp_err;
      end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, 32'(rc - hs), 32'(lat));
    chk({nm, "_data"}, 32'(dv), 32'(dexp));
    chk({nm, "_carry"}, 32'(cv), 32'(cexp));
    chk({nm, "_err"}, 32'(ev), 32'(eexp));
  endtask

  initial begin
    int hs, h1, h2, h3, p0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0;
    bus.cmd_srca = '0; bus.cmd_srcb = '0; bus.cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(2'd0, 3, 0, 0, 8'hA5, 0, hs); wait_rsp("wr3", hs, 2, 0, 0, 0);
    send(2'd1, 0, 3, 0, 8'h00, 0, hs); wait_rsp("rd3", hs, 2, 'hA5, 0, 0);
    send(2'd0, 5, 0, 0, 8'h6B, 0, hs); wait_rsp("wr5", hs, 2, 0, 0, 0);
    send(2'd3, 7, 3, 5, 8'h00, 0, hs); wait_rsp("add357", hs, 4, 'h10, 1, 0);
    send(2'd1, 0, 7, 0, 8'h00, 0, hs); wait_rsp("rd7", hs, 2, 'h10, 0, 0);
    send(2'd0, 2, 0, 0, 8'h40, 0, hs); wait_rsp("wr2", hs, 2, 0, 0, 0);
    send(2'd3, 2, 2, 2, 8'h00, 0, hs); wait_rsp("add222", hs, 4, 'h80, 0, 0);
    send(2'd1, 0, 2, 0, 8'h00, 0, hs); wait_rsp("rd2", hs, 2, 'h80, 0, 0);
    send(2'd2, 0, 0, 0, 8'h00, 0, hs); wait_rsp("clear", hs, 2, 0, 0, 0);
    send(2'd1, 0, 3, 0, 8'h00, 0, hs); wait_rsp("rd3_clr", hs, 2, 0, 0, 0);
    send(2'd1, 0, 7, 0, 8'h00, 0, hs); wait_rsp("rd7_clr", hs, 2, 0, 0, 0);
    send(2'd1, 0, 20, 0, 8'h00, 0, hs); wait_rsp("rd20_oor", hs, 2, 0, 0, 1);
    send(2'd0, 31, 0, 0, 8'h5A, 0, hs); wait_rsp("wr31_oor", hs, 2, 0, 0, 1);

    p0 = pulses;
    send(2'd0, 1, 0, 0, 8'h11, 1, h1);
    send(2'd0, 4, 0, 0, 8'h22, 1, h2);
    send(2'd0, 6, 0, 0, 8'h33, 0, h3);
    repeat (4) @(posedge clk);
    #1;
    chk("stream_gap1", 32'(h2 - h1), 3);
    chk("stream_gap2", 32'(h3 - h2), 3);
    chk("stream_pulses", 32'(pulses - p0), 3);
    send(2'd1, 0, 4, 0, 8'h00, 0, hs); wait_rsp("rd4", hs, 2, 'h22, 0, 0);

    send(2'd3, 9, 4, 6, 8'h00, 0, hs);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    p0 = pulses;
    @(negedge clk);
    chk("rst_quiet_wl", 32'(gwl | rwl | wwl), 0);
    chk("rst_quiet_clr", 32'(clr), 0);
    chk("rst_quiet_rsp", 32'(bus.rsp_valid), 0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_rsp", 32'(pulses - p0), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    send(2'd1, 0, 9, 0, 8'h00, 0, hs); wait_rsp("rd9_aborted", hs, 2, 0, 0, 0);
    send(2'd1, 0, 6, 0, 8'h00, 0, hs); wait_rsp("rd6", hs, 2, 'h33, 0, 0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
